// File: rtl/ff_pkg.sv
// Shared types and constants for the quiz-host / buzzer blocks.
package ff_pkg;

  localparam int N_PLAYERS = 4;
  localparam int PLAYER_W  = 2;

  // Host round sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ARMED  = 3'd2,
    DECODE = 3'd3,
    JUDGE  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/ff_prio_dec.sv
// Lowest-set-bit priority decoder for a player mask, plus a flag that
// reports whether more than one player bit is set.
module ff_prio_dec
  import ff_pkg::*;
(
  input  logic [N_PLAYERS-1:0] mask,
  output logic [PLAYER_W-1:0]  idx,
  output logic                 multi
);

  // Scan from the top down so the lowest set bit is the last one to win
  always_comb begin
    idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (mask[i]) idx = PLAYER_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  assign multi = |(mask & (mask - N_PLAYERS'(1)));

endmodule

// File: rtl/ff_host_ctrl.sv
// Quiz-host controller: arms the buzzer, decodes the winning press, applies
// the judge's verdict to saturating per-player scores and reports the round.
module ff_host_ctrl
  import ff_pkg::*;
#(
  parameter int SCORE_W = 4,
  parameter int POINTS  = 2,
  parameter int PENALTY = 1,
  parameter int TIMEOUT = 1000,
  parameter int CLR_CYC = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           clr_scores,
  input  logic                           judge_ok,
  input  logic                           judge_bad,
  input  logic [N_PLAYERS-1:0]           first,
  input  logic [N_PLAYERS-1:0]           second,
  output logic                           round_clr,
  output logic                           armed,
  output logic [PLAYER_W-1:0]            winner,
  output logic                           winner_vld,
  output logic                           tie,
  output logic                           runner_vld,
  output logic                           no_winner,
  output logic                           round_done,
  output logic [N_PLAYERS*SCORE_W-1:0]   scores
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [SCORE_W:0] MAX_EXT = {1'b0, {SCORE_W{1'b1}}};

  state_t                 state_reg;
  logic [CLR_W-1:0]       clr_cnt_reg;
  logic [TMO_W-1:0]       tmo_cnt_reg;
  logic [N_PLAYERS-1:0]   first_reg;
  logic [SCORE_W-1:0]     score_reg [N_PLAYERS];

  logic [PLAYER_W-1:0]    dec_idx;
  logic                   dec_multi;

  logic [SCORE_W-1:0]     cur_score;
  logic [SCORE_W:0]       sum_ext;
  logic [SCORE_W:0]       diff_ext;
  logic [SCORE_W-1:0]     inc_score;
  logic [SCORE_W-1:0]     dec_score;

  // Decode the press mask captured on the ARMED -> DECODE edge
  ff_prio_dec u_prio_dec (
    .mask  (first_reg),
    .idx   (dec_idx),
    .multi (dec_multi)
  );

  // Candidate new scores for the current winner; one spare bit catches overflow/borrow
  always_comb begin
    cur_score = score_reg[winner];
    sum_ext   = {1'b0, cur_score} + (SCORE_W+1)'(POINTS);
    diff_ext  = {1'b0, cur_score} - (SCORE_W+1)'(PENALTY);
    inc_score = (sum_ext > MAX_EXT) ? {SCORE_W{1'b1}} : sum_ext[SCORE_W-1:0];
    dec_score = diff_ext[SCORE_W] ? '0 : diff_ext[SCORE_W-1:0];
  end

  // Flatten the score array onto the display bus, player 0 in the low bits
  genvar gi;
  generate
    for (gi = 0; gi < N_PLAYERS; gi++) begin : g_scores
      assign scores[gi*SCORE_W +: SCORE_W] = score_reg[gi];
    end
  endgenerate

  // Round sequencer with all outputs and scores registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      clr_cnt_reg <= '0;
      tmo_cnt_reg <= '0;
      first_reg   <= '0;
      round_clr   <= 1'b0;
      armed       <= 1'b0;
      winner      <= '0;
      winner_vld  <= 1'b0;
      tie         <= 1'b0;
      runner_vld  <= 1'b0;
      no_winner   <= 1'b0;
      round_done  <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) score_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= CLEAR;
            round_clr   <= 1'b1;
            clr_cnt_reg <= '0;
            winner_vld  <= 1'b0;
            tie         <= 1'b0;
            runner_vld  <= 1'b0;
            no_winner   <= 1'b0;
          end else if (clr_scores) begin
            for (int i = 0; i < N_PLAYERS; i++) score_reg[i] <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt_reg == CLR_W'(CLR_CYC - 1)) begin
            state_reg   <= ARMED;
            round_clr   <= 1'b0;
            armed       <= 1'b1;
            tmo_cnt_reg <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + CLR_W'(1);
          end
        end
        ARMED: begin
          // A press on the last timeout cycle still wins the round
          if (first != '0) begin
            first_reg <= first;
            state_reg <= DECODE;
            armed     <= 1'b0;
          end else if (tmo_cnt_reg == TMO_W'(TIMEOUT - 1)) begin
            state_reg  <= DONE;
            armed      <= 1'b0;
            no_winner  <= 1'b1;
            round_done <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
          end
        end
        DECODE: begin
          // The buzzer's second mask has settled by now
          winner     <= dec_idx;
          winner_vld <= 1'b1;
          tie        <= dec_multi;
          runner_vld <= |(second & ~first_reg);
          state_reg  <= JUDGE;
        end
        JUDGE: begin
          // Contradictory verdicts are ignored until the judge settles on one
          if (judge_ok && !judge_bad) begin
            score_reg[winner] <= inc_score;
            state_reg         <= DONE;
            round_done        <= 1'b1;
          end else if (judge_bad && !judge_ok) begin
            score_reg[winner] <= dec_score;
            state_reg         <= DONE;
            round_done        <= 1'b1;
          end
        end
        DONE: begin
          round_done <= 1'b0;
          state_reg  <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff_host_ctrl.sv
// Directed bench for ff_host_ctrl: table of scored rounds plus hand-written
// sequences for timeout, conflicting verdicts, score clearing and async reset.
module tb_ff_host_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, clr_scores, judge_ok, judge_bad;
  logic [3:0]  first, second;
  logic        round_clr, armed, winner_vld, tie, runner_vld, no_winner, round_done;
  logic [1:0]  winner;
  logic [15:0] scores;

  int checks   = 0;
  int failures = 0;

  ff_host_ctrl #(
    .SCORE_W (4),
    .POINTS  (2),
    .PENALTY (1),
    .TIMEOUT (8),
    .CLR_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clr_scores (clr_scores),
    .judge_ok   (judge_ok),
    .judge_bad  (judge_bad),
    .first      (first),
    .second     (second),
    .round_clr  (round_clr),
    .armed      (armed),
    .winner     (winner),
    .winner_vld (winner_vld),
    .tie        (tie),
    .runner_vld (runner_vld),
    .no_winner  (no_winner),
    .round_done (round_done),
    .scores     (scores)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [3:0]  s;
    logic        ok;
    logic        bad;
    logic [1:0]  w;
    logic        t;
    logic        r;
    logic [15:0] sc;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse start from IDLE and wait (bounded) for armed; counts round_clr-high cycles
  task automatic begin_round(output int clr_cycles, output bit got_armed);
    clr_cycles = 0;
    got_armed  = 1'b0;
    first      = 4'b0000;
    second     = 4'b0000;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (armed) begin
        got_armed = 1'b1;
        break;
      end
      if (round_clr) clr_cycles++;
      @(negedge clk);
    end
  endtask

  // Present a press in ARMED, then the runner-up mask a cycle later; ends in JUDGE
  task automatic press(input logic [3:0] f, input logic [3:0] s);
    first = f;
    @(negedge clk);
    second = s;
    @(negedge clk);
  endtask

  // Give a verdict for one cycle and check the resulting round_done pulse
  task automatic verdict(input logic ok, input logic bad, input logic [15:0] exp_sc);
    judge_ok  = ok;
    judge_bad = bad;
    @(negedge clk);
    judge_ok  = 1'b0;
    judge_bad = 1'b0;
    chk("round_done_pulse", round_done, 1'b1);
    chk("scores_after_verdict", scores, exp_sc);
    @(negedge clk);
    chk("round_done_single", round_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cc;
    bit ga;
    int k;
    bit saw_clr;

    vecs[0]  = '{4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 16'h0200};
    vecs[1]  = '{4'b1010, 4'b1011, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 16'h0220};
    vecs[2]  = '{4'b0001, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'h0220};
    vecs[3]  = '{4'b1000, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 16'h0220};
    vecs[4]  = '{4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 16'h0222};
    vecs[5]  = '{4'b0110, 4'b0001, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 16'h0212};
    vecs[6]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0214};
    vecs[7]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0216};
    vecs[8]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0218};
    vecs[9]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h021A};
    vecs[10] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h021C};
    vecs[11] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h021E};
    vecs[12] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h021F};
    vecs[13] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'h021F};
    vecs[14] = '{4'b0100, 4'b1100, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 16'h011F};

    rst        = 1'b1;
    start      = 1'b0;
    clr_scores = 1'b0;
    judge_ok   = 1'b0;
    judge_bad  = 1'b0;
    first      = 4'b0000;
    second     = 4'b0000;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {round_clr, armed, winner, winner_vld, tie, runner_vld, no_winner, round_done}, 9'd0);
    chk("reset_scores", scores, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {round_clr, armed, round_done}, 3'd0);

    // Table of complete scored rounds
    for (int i = 0; i < 15; i++) begin
      begin_round(cc, ga);
      chk("round_clr_cycles", cc, 2);
      chk("armed_seen", ga, 1'b1);
      press(vecs[i].f, vecs[i].s);
      chk("winner", winner, vecs[i].w);
      chk("winner_vld", winner_vld, 1'b1);
      chk("tie", tie, vecs[i].t);
      chk("runner_vld", runner_vld, vecs[i].r);
      chk("no_winner_press", no_winner, 1'b0);
      chk("round_done_in_judge", round_done, 1'b0);
      verdict(vecs[i].ok, vecs[i].bad, vecs[i].sc);
      chk("winner_hold", {winner_vld, winner}, {1'b1, vecs[i].w});
      $display("round %0d: first=%b second=%b ok=%0b bad=%0b winner=%0d tie=%0b runner=%0b scores=%h",
               i, vecs[i].f, vecs[i].s, vecs[i].ok, vecs[i].bad, winner, tie, runner_vld, scores);
    end

    // Both verdicts together are ignored, as is start while judging
    begin_round(cc, ga);
    press(4'b0001, 4'b0000);
    judge_ok  = 1'b1;
    judge_bad = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("both_verdicts_stay", {round_done, winner_vld, round_clr}, 3'b010);
    chk("both_verdicts_scores", scores, 16'h011F);
    judge_ok = 1'b0;
    verdict(1'b0, 1'b1, 16'h011E);
    saw_clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (round_clr || armed) saw_clr = 1'b1;
    end
    chk("start_in_judge_ignored", saw_clr, 1'b0);
    $display("conflict round: scores=%h", scores);

    // Timeout with no press
    begin_round(cc, ga);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (round_done) begin
        k = i;
        break;
      end
    end
    chk("timeout_cycles", k, 8);
    chk("timeout_flags", {no_winner, winner_vld, armed}, 3'b100);
    @(negedge clk);
    chk("timeout_done_single", round_done, 1'b0);
    $display("timeout round: cycles=%0d no_winner=%0b", k, no_winner);

    // Press on the last armed cycle beats the timeout
    begin_round(cc, ga);
    chk("no_winner_cleared", no_winner, 1'b0);
    repeat (7) @(negedge clk);
    chk("still_armed_last", {armed, round_done}, 2'b10);
    press(4'b0010, 4'b0000);
    chk("late_press_flags", {winner_vld, no_winner, round_done}, 3'b100);
    chk("late_press_winner", winner, 2'd1);
    verdict(1'b1, 1'b0, 16'h013E);
    $display("late press round: winner=%0d scores=%h", winner, scores);

    // Score clear in IDLE
    clr_scores = 1'b1;
    @(negedge clk);
    clr_scores = 1'b0;
    chk("clr_scores", scores, 16'h0000);
    $display("clear scores: scores=%h", scores);

    // Build a nonzero score, then reset asynchronously mid-ARMED
    begin_round(cc, ga);
    press(4'b1000, 4'b0000);
    verdict(1'b1, 1'b0, 16'h2000);
    begin_round(cc, ga);
    chk("armed_before_rst", armed, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {round_clr, armed, winner, winner_vld, round_done}, 6'd0);
    chk("async_rst_scores", scores, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_idle", {armed, round_clr}, 2'b00);
    $display("async reset: armed=%0b scores=%h", armed, scores);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
